// File: rtl/dl11_pkg.sv
// Shared definitions for the DL11 console register block.
// Register offsets (relative to RCSR), register bit positions, FSM state encodings.
// No logic; imported by dl11_console and uart_hs_seq.
package dl11_pkg;

  // Register offsets from the RCSR address.
  localparam logic [12:0] OFF_RCSR = 13'd0;
  localparam logic [12:0] OFF_RBUF = 13'd2;
  localparam logic [12:0] OFF_XCSR = 13'd4;
  localparam logic [12:0] OFF_XBUF = 13'd6;

  // Bit positions inside the CSRs and RBUF.
  localparam int BIT_DONE = 7;
  localparam int BIT_IE   = 6;
  localparam int BIT_OVR  = 14;
  localparam int BIT_ERR  = 15;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_REL  = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_REQ  = 2'd1,
    T_REL  = 2'd2,
    T_BUSY = 2'd3
  } tx_state_t;

  // Generic 4-phase sequencer states.
  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_REL  = 2'd2
  } hs_state_t;

endpackage

// File: rtl/uart_hs_seq.sv
// Generic 4-phase req/ack sequencer: start -> req high -> ack high -> req low -> ack low.
// Latency: req rises the cycle after start; done_pulse is combinational on the final ack drop.
// Backpressure: waits indefinitely on ack in both phases; start is ignored unless idle.
// Ports: clk, reset (async, active-high), start, ack in; req, done_pulse out.
module uart_hs_seq
  import dl11_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic done_pulse
);

  hs_state_t state, state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HS_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HS_IDLE: if (start) state_nxt = HS_REQ;
      HS_REQ:  if (ack)   state_nxt = HS_REL;
      HS_REL:  if (!ack)  state_nxt = HS_IDLE;
      default:            state_nxt = HS_IDLE;
    endcase
  end

  // req decodes straight from the state register so an async reset drops it at once.
  always_comb begin
    req        = (state == HS_REQ);
    done_pulse = (state == HS_REL) && !ack;
  end

endmodule

// File: rtl/dl11_console.sv
// DL11 console registers (RCSR/RBUF/XCSR/XBUF) bridging the I/O-page bus to a UART.
// Latency: bus access single cycle, reads combinational; XBUF write -> ld_tx_req 1 cycle; rx_empty low -> RDONE 2 cycles.
// Backpressure: XBUF writes while XREADY=0 are dropped; UART handshakes stall on ack; rx overrun sets OVR.
// Ports: bus_* CPU register access, *_int_req/_ack/int_vector interrupts, ld_tx_*/tx_* and uld_rx_*/rx_* UART side.
module dl11_console
  import dl11_pkg::*;
#(
  parameter logic [12:0] BASE_ADDR = 13'o17560,
  parameter logic [7:0]  RX_VECTOR = 8'o060,
  parameter logic [7:0]  TX_VECTOR = 8'o064
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_init,
  input  logic [12:0] bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic        bus_byte,
  input  logic [15:0] bus_data_in,
  output logic [15:0] bus_data_out,
  output logic        bus_ack,
  output logic        rx_int_req,
  output logic        tx_int_req,
  input  logic        rx_int_ack,
  input  logic        tx_int_ack,
  output logic [7:0]  int_vector,
  output logic        ld_tx_req,
  input  logic        ld_tx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_enable,
  input  logic        tx_empty,
  output logic        uld_rx_req,
  input  logic        uld_rx_ack,
  input  logic [7:0]  rx_data,
  output logic        rx_enable,
  input  logic        rx_empty
);

  localparam logic [12:0] A_RCSR = BASE_ADDR + OFF_RCSR;
  localparam logic [12:0] A_RBUF = BASE_ADDR + OFF_RBUF;
  localparam logic [12:0] A_XCSR = BASE_ADDR + OFF_XCSR;
  localparam logic [12:0] A_XBUF = BASE_ADDR + OFF_XBUF;

  // ---------------- address decode ----------------
  logic sel_rcsr, sel_rbuf, sel_xcsr, sel_xbuf, sel_any;
  logic wr_lo, rcsr_wr, xcsr_wr, xbuf_wr, rbuf_rd;

  assign sel_rcsr = (bus_addr[12:1] == A_RCSR[12:1]);
  assign sel_rbuf = (bus_addr[12:1] == A_RBUF[12:1]);
  assign sel_xcsr = (bus_addr[12:1] == A_XCSR[12:1]);
  assign sel_xbuf = (bus_addr[12:1] == A_XBUF[12:1]);
  assign sel_any  = sel_rcsr | sel_rbuf | sel_xcsr | sel_xbuf;
  assign bus_ack  = sel_any & (bus_rd | bus_wr);

  // Every implemented bit lives in the low byte, so an odd-address byte write changes nothing.
  assign wr_lo   = bus_wr & ~(bus_byte & bus_addr[0]);
  assign rcsr_wr = wr_lo & sel_rcsr;
  assign xcsr_wr = wr_lo & sel_xcsr;
  assign xbuf_wr = wr_lo & sel_xbuf;
  assign rbuf_rd = bus_rd & sel_rbuf;

  assign tx_enable = 1'b1;
  assign rx_enable = 1'b1;

  // ---------------- register state ----------------
  logic       rdone, rie, ovr, xready, xie;
  logic [7:0] rbuf;

  // ---------------- RX FSM ----------------
  rx_state_t rx_state, rx_state_nxt;
  logic      rx_start, rx_done, rx_latch, rx_take, rx_discard;

  uart_hs_seq u_rx_hs (
    .clk        (clk),
    .reset      (reset),
    .start      (rx_start),
    .ack        (uld_rx_ack),
    .req        (uld_rx_req),
    .done_pulse (rx_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= R_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      R_IDLE:  if (!rx_empty)  rx_state_nxt = R_REQ;
      R_REQ:   if (uld_rx_ack) rx_state_nxt = R_REL;
      R_REL:   if (rx_done)    rx_state_nxt = R_IDLE;
      default:                 rx_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rx_start = (rx_state == R_IDLE) && !rx_empty;
    rx_latch = (rx_state == R_REQ) && uld_rx_ack;
    // A handshake straddling bus_init finishes on the wire but its byte is thrown away.
    rx_take  = rx_latch && !bus_init && !rx_discard;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              rx_discard <= 1'b0;
    else if (rx_state_nxt == R_IDLE)        rx_discard <= 1'b0;
    else if (bus_init && rx_state != R_IDLE) rx_discard <= 1'b1;
  end

  // Receive status; a latch in the same cycle as an RBUF read wins over the read-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdone <= 1'b0;
      ovr   <= 1'b0;
      rbuf  <= 8'h00;
    end else if (bus_init) begin
      rdone <= 1'b0;
      ovr   <= 1'b0;
    end else if (rx_take) begin
      rbuf  <= rx_data;
      rdone <= 1'b1;
      if (!rbuf_rd) ovr <= ovr | rdone;
    end else if (rbuf_rd) begin
      rdone <= 1'b0;
      ovr   <= 1'b0;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t tx_state, tx_state_nxt;
  logic      tx_accept, tx_done, tx_discard;

  uart_hs_seq u_tx_hs (
    .clk        (clk),
    .reset      (reset),
    .start      (tx_accept),
    .ack        (ld_tx_ack),
    .req        (ld_tx_req),
    .done_pulse (tx_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= T_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      T_IDLE: if (tx_accept) tx_state_nxt = T_REQ;
      T_REQ:  if (ld_tx_ack) tx_state_nxt = T_REL;
      // A handshake cut across by bus_init skips the busy wait: XREADY is already back.
      T_REL:  if (tx_done)   tx_state_nxt = (tx_discard || bus_init) ? T_IDLE : T_BUSY;
      T_BUSY: if (tx_empty || bus_init) tx_state_nxt = T_IDLE;
      default:               tx_state_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    tx_accept = xbuf_wr && xready && (tx_state == T_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        tx_discard <= 1'b0;
    else if (tx_state_nxt == T_IDLE)  tx_discard <= 1'b0;
    else if (bus_init && (tx_state == T_REQ || tx_state == T_REL)) tx_discard <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xready  <= 1'b1;
      tx_data <= 8'h00;
    end else begin
      if (tx_accept) tx_data <= bus_data_in[7:0];
      if (bus_init)                                xready <= 1'b1;
      else if (tx_accept)                          xready <= 1'b0;
      else if (tx_state == T_BUSY && tx_empty)     xready <= 1'b1;
    end
  end

  // ---------------- control bits ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rie <= 1'b0;
      xie <= 1'b0;
    end else if (bus_init) begin
      rie <= 1'b0;
      xie <= 1'b0;
    end else begin
      if (rcsr_wr) rie <= bus_data_in[BIT_IE];
      if (xcsr_wr) xie <= bus_data_in[BIT_IE];
    end
  end

  // ---------------- interrupts ----------------
  // Requests fire on the rising edge of (DONE & IE), so enabling IE with DONE set also fires.
  logic rx_lvl, rx_lvl_q, tx_lvl, tx_lvl_q;
  assign rx_lvl = rdone & rie;
  assign tx_lvl = xready & xie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_lvl_q   <= 1'b0;
      tx_lvl_q   <= 1'b0;
      rx_int_req <= 1'b0;
      tx_int_req <= 1'b0;
    end else begin
      rx_lvl_q <= rx_lvl;
      tx_lvl_q <= tx_lvl;

      if (bus_init || (rcsr_wr && !bus_data_in[BIT_IE])) rx_int_req <= 1'b0;
      else if (rx_lvl && !rx_lvl_q)                      rx_int_req <= 1'b1;
      else if (rx_int_ack)                               rx_int_req <= 1'b0;

      if (bus_init || (xcsr_wr && !bus_data_in[BIT_IE])) tx_int_req <= 1'b0;
      else if (tx_lvl && !tx_lvl_q)                      tx_int_req <= 1'b1;
      else if (tx_int_ack)                               tx_int_req <= 1'b0;
    end
  end

  assign int_vector = rx_int_req ? RX_VECTOR : TX_VECTOR;

  // ---------------- read mux ----------------
  logic [15:0] rd_word;
  always_comb begin
    rd_word = 16'h0000;
    if (sel_rcsr) begin
      rd_word[BIT_DONE] = rdone;
      rd_word[BIT_IE]   = rie;
    end else if (sel_rbuf) begin
      rd_word[BIT_ERR] = ovr;
      rd_word[BIT_OVR] = ovr;
      rd_word[7:0]     = rbuf;
    end else if (sel_xcsr) begin
      rd_word[BIT_DONE] = xready;
      rd_word[BIT_IE]   = xie;
    end
  end

  assign bus_data_out = bus_rd ? rd_word : 16'h0000;

  logic unused_data_bits;
  assign unused_data_bits = ^{bus_data_in[15:8], bus_data_in[5:0]};

endmodule
